xmul_accumulator: RTL and testbench

//  Streaming accumulator downstream of the fake (min-abs, sign-xor) multiplier.

---
 rtl/xmul_accumulator_pkg.sv | 16 +
 rtl/xmul_accumulator_sat_add.sv | 24 ++
 rtl/xmul_accumulator.sv | 100 ++++++++++
 tb/tb_xmul_accumulator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xmul_accumulator_pkg.sv
// Shared definitions for the fake-multiplier accumulator: FSM encoding and
// the saturation detect used by the clamped adder.
package xmul_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } accState_t;

  // The top two bits of a one-bit-wider signed sum disagree exactly when
  // the true result does not fit the narrower destination.
  function automatic logic clampNeeded(input logic [1:0] topBits);
    return topBits[1] ^ topBits[0];
  endfunction

endpackage

// File: rtl/xmul_accumulator_sat_add.sv
// Combinational signed add of a narrow addend into a wider accumulator,
// clamped to the accumulator range with an overflow indication.
module xmul_accumulator_sat_add
  import xmul_accumulator_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic signed [OUT_W-1:0] accIn,
  input  logic signed [IN_W-1:0]  addend,
  output logic signed [OUT_W-1:0] sum,
  output logic                    ovf
);

  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [OUT_W:0] wide;

  assign wide = {accIn[OUT_W-1], accIn} + {{(OUT_W+1-IN_W){addend[IN_W-1]}}, addend};
  assign ovf  = clampNeeded(wide[OUT_W -: 2]);
  assign sum  = ovf ? (wide[OUT_W] ? OUT_MIN : OUT_MAX) : wide[OUT_W-1:0];

endmodule

// File: rtl/xmul_accumulator.sv
// Streaming saturating accumulator: sums VEC_LEN signed products per result,
// with valid/ready on both sides and a sticky per-vector saturation flag.
//
//   state | meaning
//   ACCUM | collecting products, no result held
//   FULL  | result held on out_sum/out_sat, out_valid=1
module xmul_accumulator
  import xmul_accumulator_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 16,
  parameter int VEC_LEN = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_prod,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     out_sat
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  generate
    if (ACC_W < DATA_W) begin : gBadAccW
      $error("ACC_W must be >= DATA_W");
    end
    if (VEC_LEN < 1) begin : gBadVecLen
      $error("VEC_LEN must be >= 1");
    end
  endgenerate

  accState_t               state;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sumNext;
  logic                    satFlag;
  logic                    ovf;
  logic                    beatAccept;
  logic                    lastBeat;

  // Ready looks through to out_ready so a held result can be drained and a
  // new beat taken in the same cycle.
  assign in_ready   = (state == ACCUM) | out_ready;
  assign beatAccept = in_valid & in_ready;
  assign lastBeat   = (cnt == LAST_CNT);

  xmul_accumulator_sat_add #(
    .IN_W  (DATA_W),
    .OUT_W (ACC_W)
  ) uSatAdd (
    .accIn  (acc),
    .addend (in_prod),
    .sum    (sumNext),
    .ovf    (ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      satFlag   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        state     <= ACCUM;
        out_valid <= 1'b0;
      end
      // flush clears only the partial vector; a held result survives it
      if (flush) begin
        acc     <= '0;
        cnt     <= '0;
        satFlag <= 1'b0;
      end else if (beatAccept) begin
        if (lastBeat) begin
          out_sum   <= sumNext;
          out_sat   <= satFlag | ovf;
          out_valid <= 1'b1;
          state     <= FULL;
          acc       <= '0;
          cnt       <= '0;
          satFlag   <= 1'b0;
        end else begin
          acc     <= sumNext;
          cnt     <= cnt + CNT_W'(1);
          satFlag <= satFlag | ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_xmul_accumulator.sv
// Scoreboard bench for xmul_accumulator: a 16-bit and an 8-bit accumulator
// share one stimulus stream and are checked against a saturating model.
module tb_xmul_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [7:0] in_prod = '0;

  logic in_readyA, out_validA, out_satA;
  logic signed [15:0] out_sumA;
  logic in_readyB, out_validB, out_satB;
  logic signed [7:0] out_sumB;

  int checks = 0;
  int errors = 0;

  int expSumA[$], expSatA[$], gotSumA[$], gotSatA[$];
  int expSumB[$], expSatB[$], gotSumB[$], gotSatB[$];
  int mAccA = 0, mCntA = 0, mAccB = 0, mCntB = 0;
  bit mSatA = 0, mSatB = 0;

  always #5 clk = ~clk;

  xmul_accumulator #(.DATA_W(8), .ACC_W(16), .VEC_LEN(9)) dutA (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_readyA), .in_prod(in_prod), .out_valid(out_validA),
    .out_ready(out_ready), .out_sum(out_sumA), .out_sat(out_satA)
  );

  xmul_accumulator #(.DATA_W(8), .ACC_W(8), .VEC_LEN(9)) dutB (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_readyB), .in_prod(in_prod), .out_valid(out_validB),
    .out_ready(out_ready), .out_sum(out_sumB), .out_sat(out_satB)
  );

  function automatic int satAdd(input int a, input int p, input int w, output bit o);
    int s, hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    s = a + p;
    o = 1'b0;
    if (s > hi) begin s = hi; o = 1'b1; end
    else if (s < lo) begin s = lo; o = 1'b1; end
    return s;
  endfunction

  // One clock: drive at posedge+1, observe handshakes at negedge, update model.
  task automatic cycle(input bit v, input int p, input bit fl, input bit rdy, output bit accA);
    bit accB, o;
    int s;
    in_valid = v; in_prod = 8'(p); flush = fl; out_ready = rdy;
    @(negedge clk);
    if (out_validA && out_ready) begin gotSumA.push_back(int'(out_sumA)); gotSatA.push_back(int'(out_satA)); end
    if (out_validB && out_ready) begin gotSumB.push_back(int'(out_sumB)); gotSatB.push_back(int'(out_satB)); end
    accA = in_valid && in_readyA;
    accB = in_valid && in_readyB;
    if (fl) begin
      mAccA = 0; mCntA = 0; mSatA = 0;
      mAccB = 0; mCntB = 0; mSatB = 0;
    end else begin
      if (accA) begin
        s = satAdd(mAccA, p, 16, o);
        mSatA = mSatA | o;
        if (mCntA == 8) begin
          expSumA.push_back(s); expSatA.push_back(int'(mSatA));
          mAccA = 0; mCntA = 0; mSatA = 0;
        end else begin mAccA = s; mCntA++; end
      end
      if (accB) begin
        s = satAdd(mAccB, p, 8, o);
        mSatB = mSatB | o;
        if (mCntB == 8) begin
          expSumB.push_back(s); expSatB.push_back(int'(mSatB));
          mAccB = 0; mCntB = 0; mSatB = 0;
        end else begin mAccB = s; mCntB++; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b1, a);
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_prod = 8'sd5; out_ready = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_validA !== 1'b0 || out_sumA !== 16'sd0 || out_satA !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got valid=%b sum=%0d sat=%b want 0/0/0", out_validA, out_sumA, out_satA);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_readyA !== 1'b1 || out_validA !== 1'b0 || out_sumA !== 16'sd0 || out_validB !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b valid=%b sum=%0d validB=%b want 1/0/0/0",
               in_readyA, out_validA, out_sumA, out_validB);
    end
  endtask

  task automatic test_basic();
    bit a;
    int e, g, es, gs;
    for (int i = 0; i < 8; i++) cycle(1'b1, 3, 1'b0, 1'b1, a);
    checks++;
    if (out_validA !== 1'b0) begin errors++; $display("FAIL basic_early got valid=%b want 0", out_validA); end
    cycle(1'b1, 3, 1'b0, 1'b1, a);
    checks++;
    if (out_validA !== 1'b1 || out_sumA !== 16'sd27 || out_satA !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency got valid=%b sum=%0d sat=%b want 1/27/0", out_validA, out_sumA, out_satA);
    end
    idle(3);
    while (expSumA.size() > 0 && gotSumA.size() > 0) begin
      e = expSumA.pop_front(); g = gotSumA.pop_front(); es = expSatA.pop_front(); gs = gotSatA.pop_front();
      checks++;
      if (g !== e || gs !== es) begin errors++; $display("FAIL basic_sb got %0d/%0d want %0d/%0d", g, gs, e, es); end
    end
    checks++;
    if (expSumA.size() != 0 || gotSumA.size() != 0) begin
      errors++; $display("FAIL basic_count got %0d want %0d", gotSumA.size(), expSumA.size());
    end
    expSumB.delete(); expSatB.delete(); gotSumB.delete(); gotSatB.delete();
  endtask

  task automatic test_saturate();
    bit a;
    int e, g, es, gs;
    for (int i = 0; i < 9; i++) cycle(1'b1, 100, 1'b0, 1'b1, a);
    checks++;
    if (out_sumB !== 8'sd127 || out_satB !== 1'b1 || out_sumA !== 16'sd900 || out_satA !== 1'b0) begin
      errors++;
      $display("FAIL sat_pos got B=%0d/%b A=%0d/%b want 127/1 900/0", out_sumB, out_satB, out_sumA, out_satA);
    end
    for (int i = 0; i < 9; i++) cycle(1'b1, -1, 1'b0, 1'b1, a);
    checks++;
    if (out_sumB !== -8'sd9 || out_satB !== 1'b0) begin
      errors++; $display("FAIL sat_clear got %0d/%b want -9/0", out_sumB, out_satB);
    end
    idle(3);
    while (expSumB.size() > 0 && gotSumB.size() > 0) begin
      e = expSumB.pop_front(); g = gotSumB.pop_front(); es = expSatB.pop_front(); gs = gotSatB.pop_front();
      checks++;
      if (g !== e || gs !== es) begin errors++; $display("FAIL sat_sbB got %0d/%0d want %0d/%0d", g, gs, e, es); end
    end
    while (expSumA.size() > 0 && gotSumA.size() > 0) begin
      e = expSumA.pop_front(); g = gotSumA.pop_front(); es = expSatA.pop_front(); gs = gotSatA.pop_front();
      checks++;
      if (g !== e || gs !== es) begin errors++; $display("FAIL sat_sbA got %0d/%0d want %0d/%0d", g, gs, e, es); end
    end
    checks++;
    if (expSumB.size() != 0 || gotSumB.size() != 0 || expSumA.size() != 0 || gotSumA.size() != 0) begin
      errors++; $display("FAIL sat_count got %0d want %0d", gotSumB.size(), expSumB.size());
    end
  endtask

  task automatic test_back_to_back();
    bit a;
    int accepted, e, g, es, gs;
    for (int i = 0; i < 9; i++) cycle(1'b1, 2, 1'b0, 1'b0, a);
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1, 1'b0, 1'b0, a);
      if (a) accepted++;
      checks++;
      if (out_validA !== 1'b1 || out_sumA !== 16'sd18) begin
        errors++; $display("FAIL stall_hold got valid=%b sum=%0d want 1/18", out_validA, out_sumA);
      end
    end
    checks++;
    if (accepted != 0) begin errors++; $display("FAIL stall_ready got %0d accepted want 0", accepted); end
    accepted = 0;
    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, 1, 1'b0, 1'b1, a);
      if (a) accepted++;
      if (i == 8) begin
        checks++;
        if (out_validA !== 1'b1 || out_sumA !== 16'sd9) begin
          errors++; $display("FAIL b2b_first got valid=%b sum=%0d want 1/9", out_validA, out_sumA);
        end
      end
    end
    checks++;
    if (accepted != 18) begin errors++; $display("FAIL b2b_bubble got %0d accepted want 18", accepted); end
    idle(3);
    while (expSumA.size() > 0 && gotSumA.size() > 0) begin
      e = expSumA.pop_front(); g = gotSumA.pop_front(); es = expSatA.pop_front(); gs = gotSatA.pop_front();
      checks++;
      if (g !== e || gs !== es) begin errors++; $display("FAIL b2b_sb got %0d/%0d want %0d/%0d", g, gs, e, es); end
    end
    checks++;
    if (expSumA.size() != 0 || gotSumA.size() != 0) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", gotSumA.size(), expSumA.size());
    end
    expSumB.delete(); expSatB.delete(); gotSumB.delete(); gotSatB.delete();
  endtask

  task automatic test_flush();
    bit a;
    int e, g, es, gs;
    for (int i = 0; i < 4; i++) cycle(1'b1, 5, 1'b0, 1'b1, a);
    cycle(1'b1, 5, 1'b1, 1'b1, a);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1, 1'b0, 1'b0, a);
    checks++;
    if (out_validA !== 1'b1 || out_sumA !== 16'sd9) begin
      errors++; $display("FAIL flush_sum got valid=%b sum=%0d want 1/9", out_validA, out_sumA);
    end
    cycle(1'b0, 0, 1'b1, 1'b0, a);
    checks++;
    if (out_validA !== 1'b1 || out_sumA !== 16'sd9) begin
      errors++; $display("FAIL flush_pending got valid=%b sum=%0d want 1/9", out_validA, out_sumA);
    end
    idle(3);
    while (expSumA.size() > 0 && gotSumA.size() > 0) begin
      e = expSumA.pop_front(); g = gotSumA.pop_front(); es = expSatA.pop_front(); gs = gotSatA.pop_front();
      checks++;
      if (g !== e || gs !== es) begin errors++; $display("FAIL flush_sb got %0d/%0d want %0d/%0d", g, gs, e, es); end
    end
    checks++;
    if (expSumA.size() != 0 || gotSumA.size() != 0) begin
      errors++; $display("FAIL flush_count got %0d want %0d", gotSumA.size(), expSumA.size());
    end
    expSumB.delete(); expSatB.delete(); gotSumB.delete(); gotSatB.delete();
  endtask

  task automatic test_random();
    bit a, v, r, f;
    int p, e, g, es, gs;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 6);
      f = ($urandom_range(0, 99) < 2);
      p = $urandom_range(0, 255) - 128;
      cycle(v, p, f, r, a);
    end
    idle(4);
    checks++;
    if (expSumA.size() < 10 || expSumA.size() != gotSumA.size() || expSumB.size() != gotSumB.size()) begin
      errors++;
      $display("FAIL rand_count got A=%0d B=%0d want A=%0d B=%0d (min 10)",
               gotSumA.size(), gotSumB.size(), expSumA.size(), expSumB.size());
    end
    while (expSumA.size() > 0 && gotSumA.size() > 0) begin
      e = expSumA.pop_front(); g = gotSumA.pop_front(); es = expSatA.pop_front(); gs = gotSatA.pop_front();
      checks++;
      if (g !== e || gs !== es) begin errors++; $display("FAIL rand_sbA got %0d/%0d want %0d/%0d", g, gs, e, es); end
    end
    while (expSumB.size() > 0 && gotSumB.size() > 0) begin
      e = expSumB.pop_front(); g = gotSumB.pop_front(); es = expSatB.pop_front(); gs = gotSatB.pop_front();
      checks++;
      if (g !== e || gs !== es) begin errors++; $display("FAIL rand_sbB got %0d/%0d want %0d/%0d", g, gs, e, es); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_back_to_back();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
